// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - ID read, issue and WB write bundle for the register file
`ifndef WORDLENGTH
`define WORDLENGTH 32
`endif

interface regfile_scoreboard_if #(
  parameter int W     = `WORDLENGTH,
  parameter int ADDRW = 5
);
  logic [ADDRW-1:0] rs_addr;
  logic [ADDRW-1:0] rt_addr;
  logic [W-1:0]     rs_data;
  logic [W-1:0]     rt_data;
  logic             issue_valid;
  logic             issue_regwrite;
  logic [ADDRW-1:0] issue_rd;
  logic             wb_regwrite;
  logic [ADDRW-1:0] wb_rd;
  logic [W-1:0]     wb_data;
  logic             hazard;
  logic             sb_err;

  modport master (
    output rs_addr, rt_addr, issue_valid, issue_regwrite, issue_rd,
           wb_regwrite, wb_rd, wb_data,
    input  rs_data, rt_data, hazard, sb_err
  );

  modport slave (
    input  rs_addr, rt_addr, issue_valid, issue_regwrite, issue_rd,
           wb_regwrite, wb_rd, wb_data,
    output rs_data, rt_data, hazard, sb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - MIPS register file with per-register pending-write scoreboard
// Optional write-through bypass with hazard suppression: REGFILE_BYPASS_EN.
`ifndef WORDLENGTH
`define WORDLENGTH 32
`endif

module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int ADDRW = 5,
  parameter int PENDW = 2,
  parameter int W     = `WORDLENGTH
) (
  input logic              clk,
  input logic              reset,
  regfile_scoreboard_if.slave rf
);

  localparam logic [PENDW-1:0] PEND_MAX = '1;
  localparam logic [PENDW-1:0] PEND_ONE = PENDW'(1);

  logic [W-1:0]     regs_q [NREGS];
  logic [W-1:0]     regs_d [NREGS];
  logic [PENDW-1:0] pend_q [NREGS];
  logic [PENDW-1:0] pend_d [NREGS];
  logic             sb_err_q, sb_err_d;

  logic inc, dec, same_reg;
  logic rs_pend, rt_pend;

  assign inc      = rf.issue_valid & rf.issue_regwrite & (rf.issue_rd != '0);
  assign dec      = rf.wb_regwrite & (rf.wb_rd != '0);
  assign same_reg = inc & dec & (rf.issue_rd == rf.wb_rd);

  always_comb begin
    regs_d   = regs_q;
    pend_d   = pend_q;
    sb_err_d = sb_err_q;
    if (dec) regs_d[rf.wb_rd] = rf.wb_data;
    // A same-register issue and retire cancel; overflow/underflow saturate and flag.
    if (!same_reg) begin
      if (inc) begin
        if (pend_q[rf.issue_rd] == PEND_MAX) sb_err_d = 1'b1;
        else pend_d[rf.issue_rd] = pend_q[rf.issue_rd] + PEND_ONE;
      end
      if (dec) begin
        if (pend_q[rf.wb_rd] == '0) sb_err_d = 1'b1;
        else pend_d[rf.wb_rd] = pend_q[rf.wb_rd] - PEND_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
        pend_q[i] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      pend_q   <= pend_d;
      sb_err_q <= sb_err_d;
    end
  end

  always_comb begin
    rs_pend = (rf.rs_addr != '0) && (pend_q[rf.rs_addr] != '0);
    rt_pend = (rf.rt_addr != '0) && (pend_q[rf.rt_addr] != '0);
`ifdef REGFILE_BYPASS_EN
    // The last outstanding write retiring now is forwarded, so it no longer blocks ID.
    if (dec && (rf.wb_rd == rf.rs_addr) && (pend_q[rf.rs_addr] == PEND_ONE)) rs_pend = 1'b0;
    if (dec && (rf.wb_rd == rf.rt_addr) && (pend_q[rf.rt_addr] == PEND_ONE)) rt_pend = 1'b0;
`endif
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_rs, byp_rt;
  assign byp_rs     = dec & ~reset & (rf.wb_rd == rf.rs_addr);
  assign byp_rt     = dec & ~reset & (rf.wb_rd == rf.rt_addr);
  assign rf.rs_data = byp_rs ? rf.wb_data : regs_q[rf.rs_addr];
  assign rf.rt_data = byp_rt ? rf.wb_data : regs_q[rf.rt_addr];
`else
  assign rf.rs_data = regs_q[rf.rs_addr];
  assign rf.rt_data = regs_q[rf.rt_addr];
`endif

  assign rf.hazard = rs_pend | rt_pend;
  assign rf.sb_err = sb_err_q;

endmodule
